lif_spike_capture: RTL and testbench

Digital readout for the analog leaky integrate-and-fire neuron's spike output. Synchronizes the asynchronous comparator spike line, timestamps each rising edge against a free-running 16-bit counter, buffers the timestamps in a small FIFO, and streams them out byte-serially over a valid/ready handshake toward the dedicated outputs. It sits between the analog macro's spike pin and the project's digital I/O.

---
 rtl/lif_spike_capture.sv | 195 +++++++++++++++++++
 tb/tb_lif_spike_capture.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lif_spike_capture.sv
// lif_spike_capture: synchronizes the analog LIF comparator spike line, stamps each
// accepted rising edge with a free-running 16-bit counter, queues the stamps in a FIFO
// and streams them out low byte first over a registered valid/ready port.
// Build option: define LIF_CAPTURE_REFRACT_EN to enable the refractory filter
// (REFRACT dead cycles after each accepted spike); undefined, every enabled edge counts.
module lif_spike_capture #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned REFRACT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       spike_in,
  input  logic       rd_ready,
  input  logic       clr_ovf,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       fifo_empty,
  output logic       fifo_full,
  output logic       overflow,
  output logic [7:0] spike_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StLo, StHi} state_e;

  logic          s1_q, s2_q, s3_q;
  logic [15:0]   ts_q, ts_d;
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, full_q;
  logic          ovf_q, ovf_d;
  logic [7:0]    cnt_q, cnt_d;
  state_e        state_q, state_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;

  logic          edge_det, accept, pop, push, drop, is_full, remain;
  logic [15:0]   head, nxt_head;

  assign edge_det = s2_q & ~s3_q;

`ifdef LIF_CAPTURE_REFRACT_EN
  logic [7:0] refr_q, refr_d;

  assign accept = edge_det & ena & (refr_q == 8'd0);

  // Refractory countdown runs regardless of ena so the dead time is in real cycles.
  always_comb begin
    refr_d = refr_q;
    if (accept) begin
      refr_d = 8'(REFRACT);
    end else if (refr_q != 8'd0) begin
      refr_d = refr_q - 8'd1;
    end
  end

  // Refractory counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refr_q <= 8'd0;
    end else begin
      refr_q <= refr_d;
    end
  end
`else
  logic unused_refract;

  assign accept         = edge_det & ena;
  assign unused_refract = (REFRACT == 0);
`endif

  assign pop        = (state_q == StHi) & rd_ready;
  assign is_full    = (count_q == CW'(DEPTH));
  // A full FIFO still takes the push when the head leaves on the same edge.
  assign push       = accept & (~is_full | pop);
  assign drop       = accept & is_full & ~pop;
  assign rd_ptr_nxt = rd_ptr_q + AW'(1);
  assign head       = mem_q[rd_ptr_q];
  // Entry that becomes head after a pop; a same-cycle push fills an otherwise empty FIFO.
  assign nxt_head   = (count_q > CW'(1)) ? mem_q[rd_ptr_nxt] : ts_q;
  assign remain     = (count_q > CW'(1)) | push;

  // Timestamp, FIFO bookkeeping, overflow and spike counter next state.
  always_comb begin
    ts_d     = ena ? ts_q + 16'd1 : ts_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_nxt : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    cnt_d = (accept && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  end

  // Readout FSM: low byte, then high byte; outputs computed for the next state.
  always_comb begin
    state_d    = state_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          state_d    = StLo;
          rd_valid_d = 1'b1;
          rd_data_d  = head[7:0];
        end
      end
      StLo: begin
        if (rd_ready) begin
          state_d   = StHi;
          rd_data_d = head[15:8];
        end
      end
      StHi: begin
        if (rd_ready) begin
          if (remain) begin
            state_d   = StLo;
            rd_data_d = nxt_head[7:0];
          end else begin
            state_d    = StIdle;
            rd_valid_d = 1'b0;
            rd_data_d  = 8'd0;
          end
        end
      end
      default: begin
        state_d    = StIdle;
        rd_valid_d = 1'b0;
        rd_data_d  = 8'd0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      ts_q       <= 16'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= 8'd0;
      state_q    <= StIdle;
      rd_data_q  <= 8'd0;
      rd_valid_q <= 1'b0;
    end else begin
      s1_q       <= spike_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      ts_q       <= ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == CW'(DEPTH));
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= ts_q;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign fifo_empty = empty_q;
  assign fifo_full  = full_q;
  assign overflow   = ovf_q;
  assign spike_cnt  = cnt_q;

endmodule

// File: tb/tb_lif_spike_capture.sv
// Directed bench for lif_spike_capture (default DEPTH=8, REFRACT=4).
module tb_lif_spike_capture;

  logic       clk = 1'b0;
  logic       rst_n, ena, spike_in, rd_ready, clr_ovf;
  logic [7:0] rd_data, spike_cnt;
  logic       rd_valid, fifo_empty, fifo_full, overflow;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [15:0] ts_m;
  logic [7:0]  got[$];
  logic [7:0]  exp_b[$];
  logic [15:0] exp_ts[$];
  logic [7:0]  pd;
  logic        pv;

  lif_spike_capture dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .spike_in  (spike_in),
    .rd_ready  (rd_ready),
    .clr_ovf   (clr_ovf),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .fifo_empty(fifo_empty),
    .fifo_full (fifo_full),
    .overflow  (overflow),
    .spike_cnt (spike_cnt)
  );

  always #5 clk = ~clk;

  // Reference timestamp counter used to place spikes.
  always @(posedge clk) begin
    if (!rst_n) ts_m <= 16'd0;
    else if (ena) ts_m <= ts_m + 16'd1;
  end

  // Record every byte handed over.
  always @(posedge clk) begin
    if (rst_n && rd_valid && rd_ready) got.push_back(rd_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Raise spike_in so the edge cycle sees ts == v.
  task automatic raise_at(input logic [15:0] v);
    int guard = 0;
    while (ts_m != v - 16'd2 && guard < 70000) begin
      tick();
      guard++;
    end
    if (guard >= 70000) begin
      n_checks++;
      n_fail++;
      $display("FAIL ts_reach: observed 0x%0h required 0x%0h", ts_m, v - 16'd2);
    end
    spike_in = 1'b1;
  endtask

  task automatic pulse_at(input logic [15:0] v);
    raise_at(v);
    tick();
    spike_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; spike_in = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0;
    repeat (3) tick();
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_cnt", spike_cnt, 0);

    // Single event at 0x0102 with a 3-cycle pulse; exact latency.
    rst_n = 1'b1; ena = 1'b1; rd_ready = 1'b1;
    raise_at(16'h0102);
    repeat (3) tick();
    spike_in = 1'b0;
    check("lat_written", fifo_empty, 0);
    check("lat_not_yet_valid", rd_valid, 0);
    tick();
    check("b1_valid", rd_valid, 1);
    check("b1_lo", rd_data, 8'h02);
    tick();
    check("b1_valid_hi", rd_valid, 1);
    check("b1_hi", rd_data, 8'h01);
    tick();
    check("b1_idle_valid", rd_valid, 0);
    check("b1_idle_data", rd_data, 0);
    check("b1_empty", fifo_empty, 1);
    check("b1_cnt", spike_cnt, 1);

    // Two queued events, rd_ready toggling.
    got.delete();
    rd_ready = 1'b0;
    pulse_at(16'h0234);
    pulse_at(16'h0245);
    repeat (6) tick();
    check("stall_valid", rd_valid, 1);
    check("stall_lo0", rd_data, 8'h34);
    check("stall_nonempty", fifo_empty, 0);
    for (int i = 0; i < 12; i++) begin
      rd_ready = i[0];
      pd = rd_data;
      pv = rd_valid;
      tick();
      if (pv && !rd_ready) check("stall_hold", rd_data, pd);
    end
    check("stall_nbytes", got.size(), 4);
    exp_b = '{8'h34, 8'h02, 8'h45, 8'h02};
    for (int i = 0; i < 4 && i < got.size(); i++) check("stall_byte", got[i], exp_b[i]);
    check("stall_empty", fifo_empty, 1);

    // Fill to full, then overflow; clear; set-wins-over-clear.
    got.delete();
    exp_ts.delete();
    rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_ts.push_back(ts_m + 16'd2);
      spike_in = 1'b1; tick(); spike_in = 1'b0;
      repeat (7) tick();
    end
    check("full_after8", fifo_full, 1);
    check("no_ovf_after8", overflow, 0);
    spike_in = 1'b1; tick(); spike_in = 1'b0;
    repeat (7) tick();
    check("ovf_after9", overflow, 1);
    check("full_after9", fifo_full, 1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);
    clr_ovf = 1'b1;
    spike_in = 1'b1; tick(); spike_in = 1'b0;
    tick(); tick();
    check("ovf_set_wins", overflow, 1);
    tick();
    check("ovf_clear_after", overflow, 0);
    clr_ovf = 1'b0;
    rd_ready = 1'b1;
    repeat (20) tick();
    check("drain_nbytes", got.size(), 16);
    for (int i = 0; i < 8 && 2 * i + 1 < got.size(); i++) begin
      check("drain_lo", got[2*i], {24'd0, exp_ts[i][7:0]});
      check("drain_hi", got[2*i+1], {24'd0, exp_ts[i][15:8]});
    end
    check("drain_empty", fifo_empty, 1);

    // Wrap, ena freeze with an ignored spike, then refractory pattern.
    got.delete();
    pulse_at(16'hFFFF);
    while (ts_m != 16'h0001) tick();
    ena = 1'b0;
    repeat (10) tick();
    spike_in = 1'b1; tick(); spike_in = 1'b0;
    repeat (39) tick();
    ena = 1'b1;
    pulse_at(16'h0003);
    pulse_at(16'h000A);
    pulse_at(16'h000C);
    pulse_at(16'h000F);
    repeat (12) tick();
`ifdef LIF_CAPTURE_REFRACT_EN
    exp_b = '{8'hFF, 8'hFF, 8'h03, 8'h00, 8'h0A, 8'h00, 8'h0F, 8'h00};
`else
    exp_b = '{8'hFF, 8'hFF, 8'h03, 8'h00, 8'h0A, 8'h00, 8'h0C, 8'h00, 8'h0F, 8'h00};
`endif
    check("wrap_nbytes", got.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < got.size(); i++) check("wrap_byte", got[i], exp_b[i]);
    check("wrap_no_ovf", overflow, 0);

    // Saturation of the spike counter.
    for (int i = 0; i < 300; i++) begin
      spike_in = 1'b1; tick(); spike_in = 1'b0;
      repeat (5) tick();
    end
    repeat (10) tick();
    check("cnt_sat", spike_cnt, 255);
    check("sat_no_ovf", overflow, 0);
    check("sat_empty", fifo_empty, 1);

    // Reset while the high byte is presented.
    rd_ready = 1'b0;
    spike_in = 1'b1; tick(); spike_in = 1'b0;
    repeat (5) tick();
    check("pre_rst_valid", rd_valid, 1);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    check("in_hi_valid", rd_valid, 1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", rd_valid, 0);
    check("mid_rst_empty", fifo_empty, 1);
    check("mid_rst_cnt", spike_cnt, 0);
    check("mid_rst_data", rd_data, 0);
    rst_n = 1'b1;
    repeat (5) tick();
    check("post_rst_valid", rd_valid, 0);
    check("post_rst_empty", fifo_empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
